// File: rtl/mem_scan_reader_if.sv
// Purpose : memory read port plus output word stream of the scan reader.
// Latency : n/a (wires only)
// Backpressure: out_ready from the sink stalls the stream; memory side has none.
// Ports   : mem_address/mem_write/mem_data_out (memory unit),
//           out_word/out_addr/out_valid/out_ready (valid/ready sink stream).
interface mem_scan_reader_if #(
  parameter int WORD_SIZE = 10,
  parameter int ADDR_SIZE = 8
);
  logic [ADDR_SIZE-1:0] mem_address;
  logic                 mem_write;
  logic [WORD_SIZE-1:0] mem_data_out;
  logic [WORD_SIZE-1:0] out_word;
  logic [ADDR_SIZE-1:0] out_addr;
  logic                 out_valid;
  logic                 out_ready;

  // Scan reader side.
  modport master (
    output mem_address, mem_write, out_word, out_addr, out_valid,
    input  mem_data_out, out_ready
  );

  // Memory unit / sink side.
  modport slave (
    input  mem_address, mem_write, out_word, out_addr, out_valid,
    output mem_data_out, out_ready
  );
endinterface

// File: rtl/mem_scan_reader.sv
// Purpose : walks first..last (inclusive, wrapping) through a 1-cycle-latency memory, streams {addr, word}.
// Latency : first word valid 2 cycles after the first issue cycle; one word per cycle when unstalled.
// Backpressure: 2-entry buffer; issue stalls once buffer + in-flight read would exceed 2, nothing dropped.
// Ports   : clk, rst_n (async active-low), i_start/i_first_addr/i_last_addr (scan command),
//           o_busy/o_done (status), bus (memory port + output stream, master modport).
module mem_scan_reader #(
  parameter int WORD_SIZE = 10,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [ADDR_SIZE-1:0] i_first_addr,
  input  logic [ADDR_SIZE-1:0] i_last_addr,
  output logic                 o_busy,
  output logic                 o_done,
  mem_scan_reader_if.master    bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] word;
  } entry_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_SIZE-1:0] r_ptr;
  logic [ADDR_SIZE:0]   r_remaining;
  logic                 r_inflight;
  logic [ADDR_SIZE-1:0] r_inflight_addr;
  entry_t               r_buf [2];
  logic                 r_wr_idx;
  logic                 r_rd_idx;
  logic [1:0]           r_count;
  logic                 r_done;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_issue;
  logic                 w_last_issue;
  logic                 w_drain_done;
  logic [1:0]           w_outstanding;
  logic [ADDR_SIZE-1:0] w_span;

  assign w_span        = i_last_addr - i_first_addr;
  assign w_push        = r_inflight;
  assign w_pop         = (r_count != 2'd0) && bus.out_ready;
  assign w_outstanding = r_count + {1'b0, r_inflight};

  // A pop in this cycle frees a slot before the new read returns, so issuing
  // alongside it keeps buffer + in-flight at 2 or below while sustaining
  // one word per cycle under continuous out_ready.
  assign w_issue      = (r_state == S_READ) && ((w_outstanding < 2'd2) || w_pop);
  assign w_last_issue = w_issue && (r_remaining == (ADDR_SIZE+1)'(1));

  // Finishes on the edge that empties the buffer with nothing left in flight.
  assign w_drain_done = (r_state == S_DRAIN) && !r_inflight &&
                        ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start)      w_state_nxt = S_READ;
      S_READ:  if (w_last_issue) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drain_done) w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr           <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
      r_buf[0]        <= '0;
      r_buf[1]        <= '0;
      r_wr_idx        <= 1'b0;
      r_rd_idx        <= 1'b0;
      r_count         <= 2'd0;
      r_done          <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && i_start) begin
        r_ptr       <= i_first_addr;
        r_remaining <= {1'b0, w_span} + (ADDR_SIZE+1)'(1);
      end else if (w_issue) begin
        r_ptr       <= r_ptr + ADDR_SIZE'(1);
        r_remaining <= r_remaining - (ADDR_SIZE+1)'(1);
      end

      // Memory data for the address issued last cycle is valid now.
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_addr <= r_ptr;
      end

      if (w_push) begin
        r_buf[r_wr_idx] <= '{addr: r_inflight_addr, word: bus.mem_data_out};
        r_wr_idx        <= ~r_wr_idx;
      end
      if (w_pop) begin
        r_rd_idx <= ~r_rd_idx;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase

      r_done <= w_drain_done;
    end
  end

  assign bus.mem_address = r_ptr;
  assign bus.mem_write   = 1'b0;
  assign bus.out_word    = r_buf[r_rd_idx].word;
  assign bus.out_addr    = r_buf[r_rd_idx].addr;
  assign bus.out_valid   = (r_count != 2'd0);

  // The done cycle is already IDLE, so busy drops exactly as done rises.
  assign o_busy = (r_state != S_IDLE);
  assign o_done = r_done;

endmodule

// File: tb/tb_mem_scan_reader.sv
// Purpose : scoreboard bench for mem_scan_reader with a 1-cycle-latency memory model.
// Latency : n/a
// Backpressure: sink ready is either held high or randomised (~30% high).
module tb_mem_scan_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [7:0] i_first_addr = 8'h00;
  logic [7:0] i_last_addr = 8'h00;
  logic       o_busy;
  logic       o_done;

  mem_scan_reader_if #(.WORD_SIZE(10), .ADDR_SIZE(8)) bus ();

  mem_scan_reader #(.WORD_SIZE(10), .ADDR_SIZE(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_first_addr (i_first_addr),
    .i_last_addr  (i_last_addr),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .bus          (bus.master)
  );

  always #5 clk = ~clk;

  logic [9:0]  mem [256];
  logic [17:0] sb [$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          xfers = 0;
  bit          rdy_mode = 1'b0;
  bit          saw_write = 1'b0;
  bit          pending_done = 1'b0;
  bit          prev_stall = 1'b0;
  logic [17:0] prev_ent = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Synchronous memory: data for the address sampled at an edge appears after it.
  initial begin
    bus.mem_data_out = '0;
    forever begin
      @(posedge clk);
      bus.mem_data_out <= mem[bus.mem_address];
    end
  end

  // Sink + scoreboard monitor, working on the falling edge.
  initial begin
    logic [17:0] exp_ent;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.mem_write) saw_write = 1'b1;
      if (!rst_n) begin
        prev_stall   = 1'b0;
        pending_done = 1'b0;
      end else begin
        if (prev_stall)
          chk("stall_hold", {bus.out_valid, bus.out_addr, bus.out_word}, {1'b1, prev_ent});
        if (pending_done) begin
          chk("done_pulse", o_done, 1);
          chk("busy_fall", o_busy, 0);
          pending_done = 1'b0;
        end else if (o_done) begin
          chk("done_early", o_done, 0);
        end
        bus.out_ready = rdy_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            chk("extra_xfer", {bus.out_addr, bus.out_word}, 18'h3FFFF);
          end else begin
            exp_ent = sb.pop_front();
            chk("xfer", {bus.out_addr, bus.out_word}, exp_ent);
            xfers++;
            if (sb.size() == 0) pending_done = 1'b1;
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_ent   = {bus.out_addr, bus.out_word};
        if (rdy_mode && o_busy)
          chk("outstanding", (int'(dut.r_count) + int'(dut.r_inflight)) <= 2, 1);
      end
    end
  end

  // Runs one scan from a falling edge; returns on the falling edge where done is seen.
  task automatic run_scan(input logic [7:0] f, input logic [7:0] l,
                          input bit timing, input bit inject);
    int         n;
    logic [7:0] a;
    bit         got_done;
    n = int'(8'(l - f)) + 1;
    for (int i = 0; i < n; i++) begin
      a = f + 8'(i);
      sb.push_back({a, mem[a]});
    end
    i_first_addr = f;
    i_last_addr  = l;
    i_start      = 1'b1;
    @(posedge clk);
    #1;
    i_start      = 1'b0;
    i_first_addr = ~f;      // later changes must not matter
    i_last_addr  = f;
    got_done     = 1'b0;
    for (int j = 1; j <= 3000 && !got_done; j++) begin
      @(negedge clk);
      if (timing && j == 2) chk("lat_before_e2", bus.out_valid, 0);
      if (timing && j == 3) chk("lat_at_e2", bus.out_valid, 1);
      if (inject && j == 4) begin
        i_start      = 1'b1;
        i_first_addr = 8'h80;
        i_last_addr  = 8'h9F;
      end
      if (inject && j == 5) i_start = 1'b0;
      if (o_done) begin
        got_done = 1'b1;
        if (timing) chk("scan_cycles", j, n + 3);
      end
    end
    i_start = 1'b0;
    if (!got_done) chk("done_timeout", 0, 1);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int base;
    bit hit;
    for (int i = 0; i < 256; i++) mem[i] = 10'($urandom_range(0, 1023));
    mem[8'h10] = 10'h001;
    mem[8'h11] = 10'h0AA;
    mem[8'h12] = 10'h155;
    mem[8'h13] = 10'h3FF;

    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_addr", bus.mem_address, 0);
    chk("rst_word", {bus.out_addr, bus.out_word}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_scan(8'h10, 8'h13, 1'b1, 1'b0);
    run_scan(8'hFE, 8'h01, 1'b1, 1'b0);   // back-to-back, wraps
    run_scan(8'h42, 8'h42, 1'b1, 1'b0);
    run_scan(8'h00, 8'hFF, 1'b1, 1'b0);
    rdy_mode = 1'b1;
    run_scan(8'h00, 8'h1F, 1'b0, 1'b0);
    rdy_mode = 1'b0;
    @(negedge clk);
    run_scan(8'h40, 8'h47, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    chk("inject_busy", o_busy, 0);
    chk("inject_valid", bus.out_valid, 0);

    // Reset in the middle of a 16-word scan.
    base = xfers;
    for (int i = 0; i < 16; i++) sb.push_back({8'h30 + 8'(i), mem[8'h30 + 8'(i)]});
    i_first_addr = 8'h30;
    i_last_addr  = 8'h3F;
    i_start      = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(posedge clk);
      if (xfers >= base + 3) hit = 1'b1;
    end
    if (!hit) chk("rst_scan_timeout", 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_done", o_done, 0);
    chk("arst_addr", bus.mem_address, 0);
    chk("arst_word", {bus.out_addr, bus.out_word}, 0);
    chk("arst_xfers", xfers - base, 3);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = xfers;
    run_scan(8'h20, 8'h21, 1'b1, 1'b0);
    chk("post_rst_xfers", xfers - base, 2);
    repeat (4) @(negedge clk);

    chk("mem_write_never", saw_write, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
